// File: rtl/rr_arb_mux_pkg.sv
// Shared mode encodings and bus helpers for the round-robin arbitrating mux.
package rr_arb_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceilings for chan_word: SIZE and CHANNELS*SIZE must not exceed them.
  localparam int MAX_SIZE = 1024;
  localparam int MAX_BUS  = 8192;

  // Channel k of a flattened bus where each channel is `size` bits wide.
  function automatic logic [MAX_SIZE-1:0] chan_word(
    input logic [MAX_BUS-1:0] bus,
    input int unsigned        k,
    input int unsigned        size
  );
    logic [MAX_BUS-1:0] shifted;
    shifted = bus >> (k * size);
    return shifted[MAX_SIZE-1:0];
  endfunction

endpackage

// File: rtl/rr_arb_mux_pick.sv
// Rotating-priority picker: first set req after base, modulo CHANNELS, base last.
// Purely combinational.
module rr_pick #(
  parameter  int CHANNELS = 4,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SELW-1:0]     base,
  output logic                gnt_valid,
  output logic [SELW-1:0]     gnt_idx
);

  // Walk from the farthest offset to the nearest so the nearest hit wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = CHANNELS; i >= 1; i--) begin
      logic [SELW-1:0] idx;
      idx = SELW'((int'(base) + i) % CHANNELS);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel mux with a registered output stage, fixed-select or round-robin grant.
// One cycle from accept to out_valid; in_ready is held low while the output word stalls.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter  int SIZE     = 32,
  parameter  int CHANNELS = 4,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic [SELW-1:0]          sel,
  input  logic [CHANNELS-1:0]      in_valid,
  input  logic [CHANNELS*SIZE-1:0] in_data,
  output logic [CHANNELS-1:0]      in_ready,
  output logic                     out_valid,
  output logic [SIZE-1:0]          out_data,
  output logic [SELW-1:0]          out_chan,
  input  logic                     out_ready
);

  localparam int NPOW = 1 << SELW;

  logic [SELW-1:0] ptr;
  logic [NPOW-1:0] valid_ext;
  logic [SIZE-1:0] words [NPOW];
  logic            rr_vld;
  logic [SELW-1:0] rr_idx;
  logic            fix_vld;
  logic            grant_vld;
  logic [SELW-1:0] grant_idx;
  logic            load_en;
  logic            take;

  // Pad to a power of two so any sel/grant index lands on a defined entry.
  assign valid_ext = NPOW'(in_valid);

  for (genvar k = 0; k < NPOW; k++) begin : g_unpack
    if (k < CHANNELS) begin : g_real
      assign words[k] = SIZE'(chan_word(MAX_BUS'(in_data), k, SIZE));
    end else begin : g_pad
      assign words[k] = '0;
    end
  end

  rr_pick #(.CHANNELS(CHANNELS)) u_pick (
    .req       (in_valid),
    .base      (ptr),
    .gnt_valid (rr_vld),
    .gnt_idx   (rr_idx)
  );

  assign fix_vld = (int'(sel) < CHANNELS) && valid_ext[sel];

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (mode == MODE_RR) begin
      grant_vld = rr_vld;
      grant_idx = rr_idx;
    end else begin
      grant_vld = fix_vld;
      grant_idx = sel;
    end
  end

  assign load_en  = !out_valid || out_ready;
  assign take     = grant_vld && load_en && !reset;
  assign in_ready = take ? (CHANNELS'(1'b1) << grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SELW'(CHANNELS - 1);
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= words[grant_idx];
      out_chan  <= grant_idx;
      ptr       <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed scenarios on 4- and 3-channel instances plus a
// randomized run scored against a queue-based reference model.
module tb_rr_arb_mux;
  import rr_arb_mux_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          mode;
  logic [SW-1:0] sel;
  logic [N-1:0]  in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_chan;
  logic          out_ready;

  logic          mode3;
  logic [1:0]    sel3;
  logic [2:0]    in_valid3;
  logic [3*W-1:0] in_data3;
  logic [2:0]    in_ready3;
  logic          out_valid3;
  logic [W-1:0]  out_data3;
  logic [1:0]    out_chan3;
  logic          out_ready3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(.SIZE(W), .CHANNELS(N)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
    .out_ready(out_ready)
  );

  rr_arb_mux #(.SIZE(W), .CHANNELS(3)) dut3 (
    .clk(clk), .reset(reset), .mode(mode3), .sel(sel3),
    .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_chan(out_chan3),
    .out_ready(out_ready3)
  );

  // Channel k carries 32'hA0 + k.
  function automatic logic [N*W-1:0] pattern_bus();
    logic [N*W-1:0] b;
    for (int k = 0; k < N; k++) b[k*W +: W] = W'(32'hA0 + k);
    return b;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    mode = MODE_RR; sel = '0; in_valid = '1; in_data = pattern_bus(); out_ready = 1'b1;
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
      total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
      total++; if (out_chan !== '0) begin bad++; $display("FAIL reset_out_chan got=%0d want=0", out_chan); end
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready got=%b want=0000", in_ready); end
    end
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL post_reset_in_ready got=%b want=0001", in_ready); end
  endtask

  task automatic test_fixed_select();
    mode = MODE_FIXED; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL fixed_in_ready got=%b want=0100", in_ready); end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fixed_out_valid cyc=%0d got=%0b want=1", c, out_valid); end
      total++; if (out_data !== 32'hA2) begin bad++; $display("FAIL fixed_out_data cyc=%0d got=%h want=a2", c, out_data); end
      total++; if (out_chan !== 2'd2) begin bad++; $display("FAIL fixed_out_chan cyc=%0d got=%0d want=2", c, out_chan); end
    end
  endtask

  task automatic test_rr_fairness();
    mode = MODE_RR; in_valid = 4'b1111; out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      total++; if (out_chan !== SW'(i % N)) begin bad++; $display("FAIL rr_chan i=%0d got=%0d want=%0d", i, out_chan, i % N); end
      total++; if (out_data !== W'(32'hA0 + i % N)) begin bad++; $display("FAIL rr_data i=%0d got=%h want=%h", i, out_data, 32'hA0 + i % N); end
    end
  endtask

  task automatic test_rr_sparse();
    int exp_alt [4] = '{1, 3, 1, 3};
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++; if (out_chan !== SW'(exp_alt[i])) begin bad++; $display("FAIL sparse_chan i=%0d got=%0d want=%0d", i, out_chan, exp_alt[i]); end
    end
    in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if (out_chan !== 2'd1 || out_valid !== 1'b1) begin bad++; $display("FAIL sparse_single i=%0d got_chan=%0d got_valid=%0b want=1/1", i, out_chan, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    in_valid = 4'b1111; out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_chan !== 2'd2) begin bad++; $display("FAIL bp_load_chan got=%0d want=2", out_chan); end
    out_ready = 1'b0;
    #1;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_in_ready got=%b want=0000", in_ready); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%0b want=1", c, out_valid); end
      total++; if (out_data !== 32'hA2 || out_chan !== 2'd2) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h/%0d want=a2/2", c, out_data, out_chan); end
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_stall_ready cyc=%0d got=%b want=0000", c, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL bp_release_ready got=%b want=1000", in_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || out_chan !== 2'd3 || out_data !== 32'hA3) begin
      bad++; $display("FAIL bp_reload got=%0b/%0d/%h want=1/3/a3", out_valid, out_chan, out_data);
    end
  endtask

  task automatic test_boundary();
    logic [3*W-1:0] b3;
    // Stalled word must be dropped by reset.
    out_ready = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL drop_pre_valid got=%0b want=1", out_valid); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || out_data !== '0) begin bad++; $display("FAIL drop_valid got=%0b/%h want=0/0", out_valid, out_data); end
    reset = 1'b0;
    out_ready = 1'b1; in_valid = '0;
    for (int k = 0; k < 3; k++) b3[k*W +: W] = W'(32'hA0 + k);
    in_data3 = b3; mode3 = MODE_FIXED; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    #1;
    total++; if (in_ready3 !== 3'b000) begin bad++; $display("FAIL sel_oob_ready got=%b want=000", in_ready3); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++; if (out_valid3 !== 1'b0) begin bad++; $display("FAIL sel_oob_valid cyc=%0d got=%0b want=0", c, out_valid3); end
    end
    sel3 = 2'd2;
    #1;
    total++; if (in_ready3 !== 3'b100) begin bad++; $display("FAIL ch3_ready got=%b want=100", in_ready3); end
    @(posedge clk); #1;
    total++; if (out_valid3 !== 1'b1 || out_chan3 !== 2'd2 || out_data3 !== 32'hA2) begin
      bad++; $display("FAIL ch3_load got=%0b/%0d/%h want=1/2/a2", out_valid3, out_chan3, out_data3);
    end
    in_valid3 = '0;
  endtask

  // Reference: a one-deep queue models the output register; last_g is the
  // most recently granted channel. Mode 0 runs first, then mode 1 without reset.
  task automatic test_random();
    logic [W-1:0]  q_data[$];
    int            q_chan[$];
    int            last_g;
    int            g;
    int            c;
    bit            found;
    bit            load;
    logic [N-1:0]  exp_rdy;
    in_valid = '0; out_ready = 1'b1; mode = MODE_FIXED;
    do_reset();
    last_g = N - 1;
    for (int ph = 0; ph < 2; ph++) begin
      for (int cyc = 0; cyc < 500; cyc++) begin
        mode = 1'(ph);
        sel = SW'($urandom_range(N - 1));
        in_valid = N'($urandom);
        out_ready = ($urandom_range(3) != 0);
        for (int k = 0; k < N; k++) in_data[k*W +: W] = $urandom;
        #1;
        found = 1'b0; g = 0;
        if (ph == 0) begin
          if (in_valid[sel]) begin found = 1'b1; g = int'(sel); end
        end else begin
          for (int off = 1; off <= N; off++) begin
            c = (last_g + off) % N;
            if (!found && in_valid[c]) begin found = 1'b1; g = c; end
          end
        end
        load = (q_data.size() == 0) || out_ready;
        exp_rdy = (found && load) ? (N'(1) << g) : '0;
        total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rand_ready ph=%0d cyc=%0d got=%b want=%b", ph, cyc, in_ready, exp_rdy); end
        total++; if (out_valid !== (q_data.size() != 0)) begin bad++; $display("FAIL rand_valid ph=%0d cyc=%0d got=%0b want=%0b", ph, cyc, out_valid, q_data.size() != 0); end
        if (q_data.size() != 0 && out_ready) begin
          total++; if (out_data !== q_data[0]) begin bad++; $display("FAIL rand_data ph=%0d cyc=%0d got=%h want=%h", ph, cyc, out_data, q_data[0]); end
          total++; if (out_chan !== SW'(q_chan[0])) begin bad++; $display("FAIL rand_chan ph=%0d cyc=%0d got=%0d want=%0d", ph, cyc, out_chan, q_chan[0]); end
          void'(q_data.pop_front());
          void'(q_chan.pop_front());
        end
        if (found && load) begin
          q_data.push_back(in_data[g*W +: W]);
          q_chan.push_back(g);
          last_g = g;
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    reset = 1'b1; mode = MODE_RR; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b1;
    mode3 = MODE_FIXED; sel3 = '0; in_valid3 = '0; in_data3 = '0; out_ready3 = 1'b1;
    test_reset();
    test_fixed_select();
    test_rr_fairness();
    test_rr_sparse();
    test_backpressure();
    test_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
